// File: rtl/serial_loader4.sv
// Serial-to-parallel front end for the 4-bit load register: receives start, 4 data bits
// (LSB first) and an even-parity bit, then presents the nibble with a one-cycle load strobe.
module serial_loader4 (
  input  logic       clk,
  input  logic       reset,
  input  logic       sin,
  input  logic       sin_valid,
  output logic [3:0] word,
  output logic       load,
  output logic       busy,
  output logic       perr
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    LOAD   = 2'd3
  } state_t;

  state_t     state, state_n;
  logic [3:0] shreg, shreg_n;
  logic [1:0] cnt, cnt_n;
  logic [3:0] word_n;
  logic       load_n, perr_n, busy_n;

  // NOTE: every signal written here gets a default first, so no path leaves it unassigned
  // and no latch is inferred; blocking assignments are correct in combinational logic.
  always_comb begin
    state_n = state;
    shreg_n = shreg;
    cnt_n   = cnt;
    word_n  = word;
    load_n  = 1'b0;
    perr_n  = 1'b0;

    unique case (state)
      IDLE: begin
        if (sin_valid && sin) begin
          shreg_n = 4'b0000;
          cnt_n   = 2'd0;
          state_n = DATA;
        end
      end
      DATA: begin
        if (sin_valid) begin
          shreg_n[cnt] = sin;
          cnt_n        = cnt + 2'd1;
          if (cnt == 2'd3) state_n = PARITY;
        end
      end
      PARITY: begin
        if (sin_valid) begin
          if (sin == ^shreg) begin
            word_n  = shreg;
            state_n = LOAD;
          end else begin
            perr_n  = 1'b1;
            state_n = IDLE;
          end
        end
      end
      LOAD: begin
        // Strobe lands one cycle after word settles, matching the register's capture lag.
        load_n  = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase

    busy_n = (state_n != IDLE);
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      shreg <= 4'b0000;
      cnt   <= 2'd0;
      word  <= 4'b0000;
      load  <= 1'b0;
      perr  <= 1'b0;
      busy  <= 1'b0;
    end else begin
      state <= state_n;
      shreg <= shreg_n;
      cnt   <= cnt_n;
      word  <= word_n;
      load  <= load_n;
      perr  <= perr_n;
      busy  <= busy_n;
    end
  end

endmodule
